// File: rtl/jtdd_snd_pkg.sv
// Shared constants for the Double Dragon sound post-processor.
// Holds the FX gain table, datapath widths and the output saturation limits.
package jtdd_snd_pkg;

  localparam int unsigned SND_W    = 16;
  localparam int unsigned PROD_W   = 20;
  localparam int unsigned FRAC_DEF = 8;
  localparam int unsigned ACC_W    = SND_W + FRAC_DEF + 2;

  // Gain in quarter steps, indexed by fxlevel: {2,4,6,8} -> x0.5, x1, x1.5, x2
  localparam logic [15:0] GAIN_TAB = {4'd8, 4'd6, 4'd4, 4'd2};

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

  function automatic logic [3:0] gain_of(input logic [1:0] lvl);
    return GAIN_TAB[{lvl, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/jtdd_snd_dcblk.sv
// DC-blocking high-pass stage (one clock of latency).
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid, x   : input sample and its strobe (x held stable by the caller)
//   out_valid, y  : filtered sample, registered, with a one-cycle strobe
// With DC_EN=0 the stage is a plain register of x.
module jtdd_snd_dcblk
  import jtdd_snd_pkg::*;
#(
  parameter int unsigned DC_EN = 1,
  parameter int unsigned KDC   = 8,
  parameter int unsigned FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [SND_W-1:0] x,
  output logic                    out_valid,
  output logic signed [SND_W-1:0] y
);

  localparam int unsigned AccW = SND_W + FRAC + 2;
  localparam logic signed [AccW-1:0] YMax = AccW'(32767);
  localparam logic signed [AccW-1:0] YMin = AccW'(-32768);

  logic signed [AccW-1:0]  acc_q, acc_d, y_full;
  logic signed [SND_W-1:0] xprev_q, y_sat;
  logic signed [SND_W:0]   diff;

  always_comb begin
    diff   = {x[SND_W-1], x} - {xprev_q[SND_W-1], xprev_q};
    acc_d  = acc_q + (AccW'(diff) <<< FRAC) - (acc_q >>> KDC);
    y_full = acc_d >>> FRAC;
    // A full-scale step can push the filter output past 16 bits; clamp so the
    // gain stage product stays within its 20-bit range.
    if (y_full > YMax)      y_sat = 16'sh7fff;
    else if (y_full < YMin) y_sat = 16'sh8000;
    else                    y_sat = y_full[SND_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      xprev_q   <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        xprev_q <= x;
        if (DC_EN != 0) begin
          acc_q <= acc_d;
          y     <= y_sat;
        end else begin
          y     <= x;
        end
      end
    end
  end

endmodule

// File: rtl/jtdd_snd_post.sv
// Sound post-processor after the Double Dragon game top.
// Edge-detects the sample strobe, removes DC, applies the FX gain, saturates
// and emits a one-cycle valid three clocks after the strobe edge.
//   clk, rst     : 24 MHz sound clock, asynchronous active-high reset
//   sample_in    : game sample strobe (rising edge = new snd_in)
//   snd_in       : signed game sound
//   fxlevel      : gain select 0..3 = x0.5, x1, x1.5, x2
//   enable       : 0 mutes snd_out (filter keeps running)
//   clr_clip     : clears clip_sticky
//   snd_out      : processed sample, held between valids
//   snd_valid    : one-cycle pulse on update
//   clip         : one-cycle pulse with snd_valid when saturation occurred
//   clip_sticky  : latched clip indicator for the debug/OSD path
module jtdd_snd_post
  import jtdd_snd_pkg::*;
#(
  parameter int unsigned DC_EN = 1,
  parameter int unsigned KDC   = 8,
  parameter int unsigned FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_in,
  input  logic signed [SND_W-1:0] snd_in,
  input  logic [1:0]              fxlevel,
  input  logic                    enable,
  input  logic                    clr_clip,
  output logic signed [SND_W-1:0] snd_out,
  output logic                    snd_valid,
  output logic                    clip,
  output logic                    clip_sticky
);

  logic                    sample_d_q, v0_q, v1, sample_edge;
  logic signed [SND_W-1:0] x_q, y;

  logic signed [PROD_W-1:0] y_ext, g_ext, prod, p;
  logic signed [SND_W-1:0]  sat_val;
  logic                     sat_hit;

  assign sample_edge = sample_in & ~sample_d_q;

  // sample_d resets high so a strobe already high at reset release is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_d_q <= 1'b1;
      v0_q       <= 1'b0;
      x_q        <= '0;
    end else begin
      sample_d_q <= sample_in;
      v0_q       <= sample_edge;
      if (sample_edge) x_q <= snd_in;
    end
  end

  jtdd_snd_dcblk #(
    .DC_EN (DC_EN),
    .KDC   (KDC),
    .FRAC  (FRAC)
  ) u_dcblk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v0_q),
    .x         (x_q),
    .out_valid (v1),
    .y         (y)
  );

  // Gain and saturation share one cycle so the edge-to-valid latency is 3.
  always_comb begin
    y_ext = PROD_W'(y);
    g_ext = PROD_W'(gain_of(fxlevel));
    prod  = y_ext * g_ext;
    p     = prod >>> 2;
    if (p > SAT_MAX) begin
      sat_val = 16'sh7fff;
      sat_hit = 1'b1;
    end else if (p < SAT_MIN) begin
      sat_val = 16'sh8000;
      sat_hit = 1'b1;
    end else begin
      sat_val = p[SND_W-1:0];
      sat_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_out     <= '0;
      snd_valid   <= 1'b0;
      clip        <= 1'b0;
      clip_sticky <= 1'b0;
    end else begin
      snd_valid <= v1;
      clip      <= v1 & enable & sat_hit;
      if (v1) snd_out <= enable ? sat_val : '0;
      // set has priority over clear
      if (v1 && enable && sat_hit) clip_sticky <= 1'b1;
      else if (clr_clip)           clip_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtdd_snd_post.sv
// Scoreboard bench: u_raw (DC_EN=0) and u_dc (DC_EN=1) share all inputs
// except their sample strobes. Stimulus pushes expected results with the
// cycle they must appear on; per-DUT monitors pop and compare on snd_valid.
module tb_jtdd_snd_post;

  typedef struct {
    logic signed [15:0] val;
    logic               clp;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_a, sample_b;
  logic signed [15:0] snd_in;
  logic [1:0]         fxlevel;
  logic               enable, clr_clip;

  logic signed [15:0] a_out, b_out;
  logic               a_valid, b_valid, a_clip, b_clip, a_sticky, b_sticky;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtdd_snd_post #(.DC_EN(0), .KDC(8), .FRAC(8)) u_raw (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_a),
    .snd_in      (snd_in),
    .fxlevel     (fxlevel),
    .enable      (enable),
    .clr_clip    (clr_clip),
    .snd_out     (a_out),
    .snd_valid   (a_valid),
    .clip        (a_clip),
    .clip_sticky (a_sticky)
  );

  jtdd_snd_post #(.DC_EN(1), .KDC(8), .FRAC(8)) u_dc (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_b),
    .snd_in      (snd_in),
    .fxlevel     (fxlevel),
    .enable      (enable),
    .clr_clip    (clr_clip),
    .snd_out     (b_out),
    .snd_valid   (b_valid),
    .clip        (b_clip),
    .clip_sticky (b_sticky)
  );

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      checks++;
      if (q_a.size() == 0) begin
        fails++;
        $display("FAIL raw_unexpected_valid at cyc=%0d out=%0d", cyc, a_out);
      end else begin
        e = q_a.pop_front();
        if (a_out !== e.val || a_clip !== e.clp || cyc != e.cyc) begin
          fails++;
          $display("FAIL raw_sample got out=%0d clip=%0b cyc=%0d want out=%0d clip=%0b cyc=%0d",
                   a_out, a_clip, cyc, e.val, e.clp, e.cyc);
        end
      end
    end else if (a_clip) begin
      checks++;
      fails++;
      $display("FAIL raw_clip_without_valid at cyc=%0d", cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid) begin
      checks++;
      if (q_b.size() == 0) begin
        fails++;
        $display("FAIL dc_unexpected_valid at cyc=%0d out=%0d", cyc, b_out);
      end else begin
        e = q_b.pop_front();
        if (b_out !== e.val || b_clip !== e.clp || cyc != e.cyc) begin
          fails++;
          $display("FAIL dc_sample got out=%0d clip=%0b cyc=%0d want out=%0d clip=%0b cyc=%0d",
                   b_out, b_clip, cyc, e.val, e.clp, e.cyc);
        end
      end
    end else if (b_clip) begin
      checks++;
      fails++;
      $display("FAIL dc_clip_without_valid at cyc=%0d", cyc);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Issue one strobe edge on DUT a (which=0) or b (which=1), then idle so the
  // call returns 'gap' cycles after the edge cycle.
  task automatic edge_in(input bit which, input logic signed [15:0] v,
                         input logic signed [15:0] want, input logic want_clip,
                         input bit expect_out, input int gap);
    exp_t e;
    @(negedge clk);
    snd_in = v;
    if (which) sample_b = 1'b1;
    else       sample_a = 1'b1;
    if (expect_out) begin
      e.val = want;
      e.clp = want_clip;
      e.cyc = cyc + 3;
      if (which) q_b.push_back(e);
      else       q_a.push_back(e);
    end
    @(negedge clk);
    sample_a = 1'b0;
    sample_b = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    logic signed [15:0] gain_exp [4];
    logic signed [15:0] decay_exp [5];
    gain_exp  = '{-16'sd2, -16'sd3, -16'sd5, -16'sd6};
    decay_exp = '{16'sd1000, 16'sd996, 16'sd992, 16'sd988, 16'sd984};

    rst = 1'b1; sample_a = 1'b0; sample_b = 1'b0; snd_in = '0;
    fxlevel = 2'd1; enable = 1'b1; clr_clip = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_out_a", a_out, 0);
    chk("reset_valid_a", a_valid, 0);
    chk("reset_sticky_a", a_sticky, 0);
    chk("reset_out_b", b_out, 0);

    // Latency, pure register path
    edge_in(0, 16'sd1234, 16'sd1234, 1'b0, 1, 6);

    // Gain table, floor rounding
    for (int i = 0; i < 4; i++) begin
      fxlevel = 2'(i);
      edge_in(0, -16'sd3, gain_exp[i], 1'b0, 1, 4);
    end

    // Back-to-back edges 2 cycles apart
    fxlevel = 2'd1;
    edge_in(0, 16'sd111, 16'sd111, 1'b0, 1, 1);
    edge_in(0, 16'sd222, 16'sd222, 1'b0, 1, 5);

    // Saturation
    fxlevel = 2'd3;
    edge_in(0, 16'sd1000, 16'sd2000, 1'b0, 1, 5);
    chk("sticky_no_clip", a_sticky, 0);
    edge_in(0, 16'sd20000, 16'sd32767, 1'b1, 1, 5);
    chk("sticky_after_pos_clip", a_sticky, 1);
    edge_in(0, -16'sd20000, -16'sd32768, 1'b1, 1, 5);
    clr_clip = 1'b1;
    @(negedge clk);
    clr_clip = 1'b0;
    chk("sticky_cleared", a_sticky, 0);
    // Muted clips are not reported
    enable = 1'b0;
    edge_in(0, 16'sd20000, 16'sd0, 1'b0, 1, 5);
    chk("sticky_muted", a_sticky, 0);
    enable = 1'b1;

    // DC decay with constant input
    fxlevel = 2'd1;
    for (int i = 0; i < 5; i++) edge_in(1, 16'sd1000, decay_exp[i], 1'b0, 1, 4);
    repeat (10) @(negedge clk);

    // Mute then re-enable keeps filter state
    enable = 1'b0;
    edge_in(1, 16'sd5000, 16'sd0, 1'b0, 1, 4);
    enable = 1'b1;
    edge_in(1, 16'sd5000, 16'sd4961, 1'b0, 1, 6);

    // Reset mid-pipe: edge at N, reset at N+1, nothing may come out
    @(negedge clk);
    snd_in = 16'sd777;
    sample_a = 1'b1;
    @(negedge clk);
    sample_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_out_a", a_out, 0);
    chk("midreset_valid_a", a_valid, 0);
    chk("midreset_out_b", b_out, 0);
    sample_b = 1'b1;  // held high across release: must not count as an edge
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sample_b = 1'b0;
    repeat (2) @(negedge clk);

    // Clean state after reset
    edge_in(1, 16'sd1000, 16'sd1000, 1'b0, 1, 4);
    edge_in(0, 16'sd1234, 16'sd1234, 1'b0, 1, 6);

    repeat (4) @(negedge clk);
    chk("pending_raw", q_a.size(), 0);
    chk("pending_dc", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jtdd_snd_post.md
Name: jtdd_snd_post

Overview:
- Sound post-processor directly downstream of the Double Dragon game top.
- Consumes the game's mono signed 16-bit sound word and its sample strobe.
- Removes DC offset, applies the 2-bit FX level gain, saturates, and hands a clean sample with a one-cycle valid pulse to the platform audio output.
- Also reports clipping for the debug/OSD path.

Parameters:
- DC_EN, 1, 1 enables the DC-blocking high-pass; 0 makes that stage a pure register.
- KDC, 8, DC-blocker pole shift. Leak term is y_acc>>>KDC; cutoff ≈ fs/(2π·2^KDC).
- FRAC, 8, fractional bits kept in the DC-blocker accumulator.

Ports:
- clk  in  1  system clock (24 MHz sound domain)
- rst  in  1  reset, asynchronous, active-high
- sample_in  in  1  game sample strobe; a rising edge marks a new snd_in
- snd_in  in  16  signed game sound, valid when sample_in rises
- fxlevel  in  2  gain select: 0=×0.5, 1=×1, 2=×1.5, 3=×2
- enable  in  1  0 forces snd_out to 0; filter state keeps running
- clr_clip  in  1  clears clip_sticky
- snd_out  out  16  signed processed sample, held between valids
- snd_valid  out  1  one-cycle pulse when snd_out updates
- clip  out  1  one-cycle pulse, coincident with snd_valid, when saturation occurred
- clip_sticky  out  1  set on any clip, cleared by clr_clip or rst

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; x_prev=0, y_acc=0, pipeline valid bits 0. Reset mid-operation flushes in-flight samples, and no snd_valid is issued for them.
- Edge detect (stage 0):
  - sample_d registers sample_in.
  - An edge is sample_in && !sample_d.
  - snd_in is captured into x on the edge cycle N.
  - Sample_in already high when reset releases is not an edge.
- DC block (stage 1, cycle N+1), with DC_EN=1:
  - y_acc ← y_acc + ((x − x_prev) <<< FRAC) − (y_acc >>> KDC)
  - x_prev ← x
  - y = y_acc >>> FRAC (arithmetic shift, floor)
  - y_acc width is 16+FRAC+2 bits signed, so there is no internal wrap.
  - With DC_EN=0: y = x.
- Gain (stage 2, cycle N+2):
  - g = {2,4,6,8}[fxlevel]; p = (y·g) >>> 2, computed in 20-bit signed.
  - fxlevel is sampled at this stage; a change applies from the next sample.
- Saturate/output (stage 3, result visible at N+3):
  - p > 32767 → 32767; p < −32768 → −32768; clip=1 in either case.
  - snd_out = enable ? sat(p) : 0; snd_valid=1 for exactly one cycle.
  - clip is reported only when enable=1.
- Latency: exactly 3 clk cycles from the edge cycle to snd_valid. Throughput is one sample per 2 clk (edges are at least 2 cycles apart by construction).
- clip_sticky: set on a clip pulse; cleared on clr_clip. If both occur in the same cycle, set wins.
- Boundaries:
  - x − x_prev spans 17 bits; computed signed 17-bit, no overflow.
  - Back-to-back edges 2 cycles apart produce two distinct valids 2 cycles apart.

Decomposition:
- Package jtdd_snd_pkg holds:
  - the gain table constant {2,4,6,8}
  - width localparams: SND_W=16, PROD_W=20, ACC_W=16+FRAC+2
  - saturation limits 32767 / −32768
- One sub-module, jtdd_snd_dcblk: the stage-1 DC-blocker (clk, rst, in_valid, x, out_valid, y; parameters KDC, FRAC, DC_EN).
- Edge detect, gain and saturation remain in jtdd_snd_post.

Test Plan:
- Latency: DC_EN=0, fxlevel=1, edge with snd_in=1234 at cycle N → snd_valid only at N+3, snd_out=1234, clip=0.
- DC decay: DC_EN=1, KDC=8, FRAC=8, fxlevel=1, constant snd_in=1000 over repeated edges → outputs 1000, then 996, then monotonically decaying toward 0. No valid without an edge.
- Gain: DC_EN=0, snd_in=−3 → fxlevel 0..3 give −2, −3, −5, −6 (floor semantics).
- Saturation: DC_EN=0, fxlevel=3:
  - snd_in=20000 → 32767, clip pulse, clip_sticky=1.
  - then snd_in=−20000 → −32768.
  - clr_clip → clip_sticky=0.
- Mute: enable=0, snd_in=5000 → snd_valid pulses with snd_out=0. Re-enable → the next sample reflects filter state continuity (no restart transient).
- Reset mid-pipe: assert rst at N+1 after an edge → no snd_valid at N+3, all outputs 0. The first post-reset edge behaves as from a clean state.
